disp_arbiter: RTL

//   Shares the 4-digit seven-segment display between two frame sources (req0, req1).

---
 rtl/disp_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/disp_arbiter.sv
// Purpose : round-robin arbiter sharing one 4-digit seven-segment display between two frame sources.
// Latency : accepted frame appears on in0..in3 one clock after the valid&ready edge.
// Backpr. : ready pulses only on a frame tick for the granted source; sources hold valid/data until ready.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req0_valid/data/ready   source 0 frame offer ([7:0]=digit0 .. [31:24]=digit3, active-low segments)
//   req1_valid/data/ready   source 1 frame offer, same packing
//   in0..in3                latched segment patterns to the display multiplexer
//   owner                   index of current/last owner
//   busy                    high while an owner holds the display
//
// Build option: define DISP_ARB_BLANK_EN to blank the display when ownership lapses back to idle;
// without it the last accepted frame stays visible until reset.

module disp_arbiter #(
    parameter int TICK_DIV    = 18,
    parameter int HOLD_FRAMES = 50,
    parameter int HOLD_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3,
    output logic        owner,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_FRAMES - 1);

    state_t              state;
    logic [TICK_DIV-1:0] tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick;
    logic                own_vld;
    logic                other_vld;
    logic                gnt_vld;
    logic                gnt_sel;
    logic                gnt_fire;

    // One tick per full scan of the four digits.
    assign tick = &tick_cnt;

    // Arbitration is open in IDLE and when the hold window has run out; in both cases the
    // non-owner wins a contest, which gives req0 first pick after reset (owner resets to 1).
    // While the window is still open only the owner may refresh its frame.
    always_comb begin
        own_vld   = owner ? req1_valid : req0_valid;
        other_vld = owner ? req0_valid : req1_valid;
        gnt_vld   = 1'b0;
        gnt_sel   = owner;
        if (state == IDLE || hold_cnt == '0) begin
            if (other_vld) begin
                gnt_vld = 1'b1;
                gnt_sel = ~owner;
            end else if (own_vld) begin
                gnt_vld = 1'b1;
                gnt_sel = owner;
            end
        end else begin
            gnt_vld = own_vld;
            gnt_sel = owner;
        end
    end

    assign gnt_fire   = reset_n & tick & gnt_vld;
    assign req0_ready = gnt_fire & ~gnt_sel;
    assign req1_ready = gnt_fire & gnt_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            state    <= IDLE;
            hold_cnt <= '0;
            owner    <= 1'b1;
            busy     <= 1'b0;
            in0      <= 8'hFF;
            in1      <= 8'hFF;
            in2      <= 8'hFF;
            in3      <= 8'hFF;
        end else begin
            tick_cnt <= tick_cnt + TICK_DIV'(1);
            if (tick) begin
                if (gnt_fire) begin
                    {in3, in2, in1, in0} <= gnt_sel ? req1_data : req0_data;
                end
                if (state == IDLE) begin
                    if (gnt_fire) begin
                        owner    <= gnt_sel;
                        hold_cnt <= HOLD_RELOAD;
                        state    <= HOLD;
                        busy     <= 1'b1;
                    end
                end else begin
                    if (hold_cnt != '0) begin
                        // Owner refreshes do not extend the window.
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else if (gnt_fire) begin
                        owner    <= gnt_sel;
                        hold_cnt <= HOLD_RELOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef DISP_ARB_BLANK_EN
                        in0   <= 8'hFF;
                        in1   <= 8'hFF;
                        in2   <= 8'hFF;
                        in3   <= 8'hFF;
`endif
                    end
                end
            end
        end
    end

endmodule
